array_cmd_ctrl: RTL and testbench

//  Command front-end directly upstream of the 512x16 memory/search array. Accepts read/write/search

---
 rtl/array_pkg.sv | 32 +++
 rtl/array_cmd_fifo.sv | 73 +++++++
 rtl/array_cmd_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_array_cmd_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_pkg.sv
// Shared types for the array command front-end.
//  - op_e    : array op encoding (read, write, search, no-op)
//  - cmd_t   : queued command {op, addr, bank, data} at the default array geometry
//  - state_e : issue/response sequencer states
// No ports (package).
package array_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SEARCH = 2'b10,
    OP_NOP    = 2'b11
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] bank;
    logic [DATA_W_DEF-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/array_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of type T (power-of-2 depth).
// Ports:
//  clk, rst_n  clock / asynchronous active-low reset (pointers, count, full flag)
//  i_push      push request; ignored while full, even if a pop happens the same cycle
//  i_din       entry to push
//  i_pop       pop request; ignored while empty
//  o_dout      head entry (valid while !o_empty)
//  o_full      registered full flag
//  o_empty     empty flag
module array_cmd_fifo
  import array_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  T     i_din,
  input  logic i_pop,
  output T     o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_FULL = (PW + 1)'(DEPTH);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_full;

  logic          w_push;
  logic          w_pop;
  logic [PW:0]   w_count_nxt;

  assign w_push  = i_push && !r_full;
  assign w_pop   = i_pop && (r_count != '0);
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = (r_count == '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Full is registered from the next count so the upstream ready is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/array_cmd_ctrl.sv
// Command front-end for the 512x16 memory/search array. Commands are queued in a
// FIFO and issued one at a time; read/search results are captured RD_LAT cycles
// after issue and returned over a valid/ready response channel. Only one array op
// is outstanding; nothing is issued while a response is pending.
// Optional feature macro: ARRAY_CTRL_WRITE_ACK_EN (writes return an ack response
// with rsp_op=01, rsp_data=0; without it writes produce no response).
// Ports:
//  clk, rst_n                    clock / asynchronous active-low reset
//  cmd_valid/cmd_ready           command handshake (cmd_ready = FIFO not full, registered)
//  cmd_op/addr/bank/data         command fields (op 11 = NOP, dropped at pop)
//  rsp_valid/rsp_ready           response handshake
//  rsp_op/rsp_data               response op and read data / match vector
//  arr_op_code/addr/data_bank/data_in  array pins (op 11 on every non-issue cycle)
//  arr_rdata                     array read data / match vector
//  busy                          FIFO non-empty or sequencer not idle
module array_cmd_ctrl
  import array_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_D = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_bank,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_op,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        arr_op_code,
  output logic [ADDR_W-1:0] arr_addr,
  output logic [DATA_W-1:0] arr_data_bank,
  output logic [DATA_W-1:0] arr_data_in,
  input  logic [DATA_W-1:0] arr_rdata,
  output logic              busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] bank;
    logic [DATA_W-1:0] data;
  } cmd_w_t;

  cmd_w_t            w_cmd_in;
  cmd_w_t            w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;
  logic              w_issue;
  logic              w_capture;
  logic              w_wr_ack;
  logic              w_rsp_done;
  state_e            w_state_nxt;

  state_e            r_state;
  op_e               r_arr_op;
  op_e               r_cur_op;
  logic [ADDR_W-1:0] r_arr_addr;
  logic [DATA_W-1:0] r_arr_bank;
  logic [DATA_W-1:0] r_arr_din;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rsp_valid;
  op_e               r_rsp_op;
  logic [DATA_W-1:0] r_rsp_data;

  assign w_cmd_in.op   = op_e'(cmd_op);
  assign w_cmd_in.addr = cmd_addr;
  assign w_cmd_in.bank = cmd_bank;
  assign w_cmd_in.data = cmd_data;

  array_cmd_fifo #(
    .DEPTH (FIFO_D),
    .T     (cmd_w_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cmd_valid),
    .i_din   (w_cmd_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign cmd_ready     = !w_fifo_full;
  assign busy          = !w_fifo_empty || (r_state != ST_IDLE);
  assign arr_op_code   = r_arr_op;
  assign arr_addr      = r_arr_addr;
  assign arr_data_bank = r_arr_bank;
  assign arr_data_in   = r_arr_din;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_op        = r_rsp_op;
  assign rsp_data      = r_rsp_data;

  // The head is popped on the IDLE->ISSUE edge so the array pins are registered
  // during ISSUE. A NOP head is popped without leaving IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    w_wr_ack    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop = 1'b1;
          if (w_head.op != OP_NOP) begin
            w_issue     = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (r_cur_op == OP_WRITE) begin
`ifdef ARRAY_CTRL_WRITE_ACK_EN
          w_wr_ack    = 1'b1;
          w_state_nxt = ST_RESP;
`else
          w_state_nxt = ST_IDLE;
`endif
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_arr_op    <= OP_NOP;
      r_cur_op    <= OP_NOP;
      r_arr_addr  <= '0;
      r_arr_bank  <= '0;
      r_arr_din   <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_op    <= OP_READ;
      r_rsp_data  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_arr_op <= w_issue ? w_head.op : OP_NOP;
      if (w_issue) begin
        r_cur_op   <= w_head.op;
        r_arr_addr <= w_head.addr;
        r_arr_bank <= w_head.bank;
        r_arr_din  <= w_head.data;
      end
      // Loaded while the op is on the pins; reaches 0 in the cycle arr_rdata is valid.
      if (r_state == ST_ISSUE) begin
        r_cnt <= CNT_W'(RD_LAT - 1);
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_op    <= r_cur_op;
        r_rsp_data  <= arr_rdata;
      end else if (w_wr_ack) begin
        r_rsp_valid <= 1'b1;
        r_rsp_op    <= OP_WRITE;
        r_rsp_data  <= '0;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_array_cmd_ctrl.sv
// Testbench for array_cmd_ctrl: a behavioural array (memory + search, RD_LAT
// read pipeline) sits on the array pins; a reference model updated at command
// acceptance predicts the in-order issue trace and response stream.
`timescale 1ns/1ps
module tb_array_cmd_ctrl;
  import array_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int FIFO_D = 4;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b11;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_bank = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [1:0]        rsp_op;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        arr_op_code;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_data_bank;
  logic [DATA_W-1:0] arr_data_in;
  logic [DATA_W-1:0] arr_rdata;
  logic              busy;

  always #5 clk = ~clk;

  array_cmd_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .FIFO_D (FIFO_D),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_bank      (cmd_bank),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_op        (rsp_op),
    .rsp_data      (rsp_data),
    .arr_op_code   (arr_op_code),
    .arr_addr      (arr_addr),
    .arr_data_bank (arr_data_bank),
    .arr_data_in   (arr_data_in),
    .arr_rdata     (arr_rdata),
    .busy          (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef logic [42:0] iss_t;   // {op, addr, bank, data_in} with don't-care fields zeroed
  typedef logic [17:0] rsp_t;   // {op, data}
  iss_t q_iss[$];
  iss_t e_iss[$];
  rsp_t q_rsp[$];
  rsp_t e_rsp[$];

  logic [15:0] ref_mem [0:15];
  logic [15:0] arr_mem [0:511];
  logic [15:0] pipe    [0:RD_LAT-1];
  logic        mem_clr = 1'b0;

  function automatic iss_t iss_key(input logic [1:0] op, input logic [8:0] a,
                                   input logic [15:0] b, input logic [15:0] d);
    case (op)
      2'b00:   return {op, a, 16'h0000, d};
      2'b01:   return {op, a, b, 16'h0000};
      default: return {op, 9'h000, b, d};
    endcase
  endfunction

  // Search match vector: bit i set when bank bit i is selected and row i equals the key.
  function automatic logic [15:0] arr_search(input logic [15:0] b, input logic [15:0] k);
    logic [15:0] m = '0;
    for (int i = 0; i < 16; i++) m[i] = b[i] && (arr_mem[i] == k);
    return m;
  endfunction

  function automatic logic [15:0] ref_search(input logic [15:0] b, input logic [15:0] k);
    logic [15:0] m = '0;
    for (int i = 0; i < 16; i++) m[i] = b[i] && (ref_mem[i] == k);
    return m;
  endfunction

  // Behavioural array on the pins.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) arr_mem[i] <= 16'(i * 16'h1111);
    end else begin
      case (arr_op_code)
        2'b00:   pipe[0] <= arr_mem[arr_addr] & arr_data_in;
        2'b01:   arr_mem[arr_addr] <= arr_data_bank;
        2'b10:   pipe[0] <= arr_search(arr_data_bank, arr_data_in);
        default: ;
      endcase
    end
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign arr_rdata = pipe[RD_LAT-1];

  // Observed issue trace and response stream.
  always @(negedge clk) begin
    if (rst_n && arr_op_code != 2'b11)
      q_iss.push_back(iss_key(arr_op_code, arr_addr, arr_data_bank, arr_data_in));
    if (rst_n && rsp_valid && rsp_ready)
      q_rsp.push_back({rsp_op, rsp_data});
  end

  task automatic clear_queues();
    q_iss.delete(); e_iss.delete(); q_rsp.delete(); e_rsp.delete();
  endtask

  task automatic ref_accept(input logic [1:0] op, input logic [8:0] a,
                            input logic [15:0] b, input logic [15:0] d);
    if (op != 2'b11) e_iss.push_back(iss_key(op, a, b, d));
    case (op)
      2'b00: e_rsp.push_back({2'b00, ref_mem[a[3:0]] & d});
      2'b01: begin
        ref_mem[a[3:0]] = b;
`ifdef ARRAY_CTRL_WRITE_ACK_EN
        e_rsp.push_back({2'b01, 16'h0000});
`endif
      end
      2'b10: e_rsp.push_back({2'b10, ref_search(b, d)});
      default: ;
    endcase
  endtask

  task automatic send(input logic [1:0] op, input logic [8:0] a,
                      input logic [15:0] b, input logic [15:0] d);
    int t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_bank = b; cmd_data = d;
    @(negedge clk);
    while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL cmd_accept_timeout cmd_ready=%0b required 1", cmd_ready);
    end else begin
      ref_accept(op, a, b, d);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((busy || rsp_valid) && t < 500) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    if (busy || rsp_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout busy=%0b rsp_valid=%0b required 0/0", busy, rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int t = 0;
    rst_n = 1'b0; mem_clr = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'(i * 16'h1111);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (arr_op_code !== 2'b11 || arr_addr !== '0 || arr_data_bank !== '0 || arr_data_in !== '0) begin
      n_fail++;
      $display("FAIL reset_arr got op=%b addr=%h bank=%h din=%h required 11/0/0/0",
               arr_op_code, arr_addr, arr_data_bank, arr_data_in);
    end
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_op !== 2'b00 || rsp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp got v=%b op=%b data=%h required 0/00/0000", rsp_valid, rsp_op, rsp_data);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_clr = 1'b0;
    // Read, then pull reset while its result is still pending.
    send(2'b00, 9'd3, 16'h0000, 16'hFFFF);
    while (arr_op_code !== 2'b00 && t < 50) begin @(negedge clk); t++; end
    n_cmp++;
    if (arr_op_code !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_read_issue got op=%b required 00", arr_op_code);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (arr_op_code !== 2'b11 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got op=%b rsp_valid=%b cmd_ready=%b busy=%b required 11/0/1/0",
               arr_op_code, rsp_valid, cmd_ready, busy);
    end
    clear_queues();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (q_rsp.size() != 0 || q_iss.size() != 0) begin
      n_fail++;
      $display("FAIL reset_stale got rsp=%0d iss=%0d required 0/0", q_rsp.size(), q_iss.size());
    end
    wait_idle();
  endtask

  task automatic test_write_read();
    int t = 0;
    int n = 0;
    clear_queues(); rsp_ready = 1'b1;
    send(2'b01, 9'd0, 16'h00FF, 16'($urandom));
    send(2'b00, 9'd0, 16'($urandom), 16'h00FF);
    while (arr_op_code !== 2'b00 && t < 50) begin @(negedge clk); t++; end
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (n != RD_LAT + 1) begin
      n_fail++;
      $display("FAIL read_latency got %0d required %0d", n, RD_LAT + 1);
    end
    n_cmp++;
    if (rsp_op !== 2'b00 || rsp_data !== 16'h00FF) begin
      n_fail++;
      $display("FAIL read_rsp got op=%b data=%h required 00/00ff", rsp_op, rsp_data);
    end
    wait_idle();
    n_cmp++;
    if (q_iss.size() != 2) begin
      n_fail++;
      $display("FAIL wr_rd_issue_count got %0d required 2", q_iss.size());
    end else begin
      n_cmp++;
      if (q_iss[0] !== iss_key(2'b01, 9'd0, 16'h00FF, 16'h0) ||
          q_iss[1] !== iss_key(2'b00, 9'd0, 16'h0, 16'h00FF)) begin
        n_fail++;
        $display("FAIL wr_rd_issue got %h %h required %h %h", q_iss[0], q_iss[1],
                 iss_key(2'b01, 9'd0, 16'h00FF, 16'h0), iss_key(2'b00, 9'd0, 16'h0, 16'h00FF));
      end
    end
  endtask

  task automatic test_search();
    clear_queues(); rsp_ready = 1'b1;
    send(2'b01, 9'd1, 16'h00AA, 16'($urandom));
    send(2'b10, 9'($urandom_range(0, 15)), 16'h0001, 16'h00FF);
    send(2'b10, 9'd0, 16'hFFFF, 16'h00AA);
    wait_idle();
    n_cmp++;
    if (q_rsp.size() != e_rsp.size()) begin
      n_fail++;
      $display("FAIL search_rsp_count got %0d required %0d", q_rsp.size(), e_rsp.size());
    end
    foreach (e_rsp[i]) if (i < q_rsp.size()) begin
      n_cmp++;
      if (q_rsp[i] !== e_rsp[i]) begin
        n_fail++;
        $display("FAIL search_rsp[%0d] got %h required %h", i, q_rsp[i], e_rsp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t = 0;
    rsp_t held;
    clear_queues();
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(2'b00, 9'(2 + k), 16'($urandom), 16'hFFFF);
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full got cmd_ready=%b required 0", cmd_ready);
    end
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    held = {rsp_op, rsp_data};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || {rsp_op, rsp_data} !== held || arr_op_code !== 2'b11 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold got v=%b rsp=%h op=%b rdy=%b required 1/%h/11/0",
                 rsp_valid, {rsp_op, rsp_data}, arr_op_code, cmd_ready, held);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle();
    n_cmp++;
    if (q_rsp.size() != e_rsp.size() || q_iss.size() != e_iss.size()) begin
      n_fail++;
      $display("FAIL bp_count got rsp=%0d iss=%0d required %0d/%0d",
               q_rsp.size(), q_iss.size(), e_rsp.size(), e_iss.size());
    end
    foreach (e_rsp[i]) if (i < q_rsp.size()) begin
      n_cmp++;
      if (q_rsp[i] !== e_rsp[i]) begin
        n_fail++;
        $display("FAIL bp_rsp[%0d] got %h required %h", i, q_rsp[i], e_rsp[i]);
      end
    end
  endtask

  task automatic test_nop();
    clear_queues(); rsp_ready = 1'b1;
    send(2'b00, 9'd5, 16'($urandom), 16'($urandom));
    send(2'b11, 9'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
    send(2'b00, 9'd7, 16'($urandom), 16'($urandom));
    wait_idle();
    n_cmp++;
    if (q_iss.size() != 2 || q_rsp.size() != 2) begin
      n_fail++;
      $display("FAIL nop_count got iss=%0d rsp=%0d required 2/2", q_iss.size(), q_rsp.size());
    end
    foreach (e_iss[i]) if (i < q_iss.size()) begin
      n_cmp++;
      if (q_iss[i] !== e_iss[i]) begin
        n_fail++;
        $display("FAIL nop_iss[%0d] got %h required %h", i, q_iss[i], e_iss[i]);
      end
    end
    foreach (e_rsp[i]) if (i < q_rsp.size()) begin
      n_cmp++;
      if (q_rsp[i] !== e_rsp[i]) begin
        n_fail++;
        $display("FAIL nop_rsp[%0d] got %h required %h", i, q_rsp[i], e_rsp[i]);
      end
    end
  endtask

  task automatic test_write_ack();
    int t = 0;
    int n = 0;
    clear_queues(); rsp_ready = 1'b1;
    send(2'b01, 9'd9, 16'($urandom), 16'($urandom));
    while (arr_op_code !== 2'b01 && t < 50) begin @(negedge clk); t++; end
    while (!rsp_valid && n < 6) begin @(negedge clk); n++; end
`ifdef ARRAY_CTRL_WRITE_ACK_EN
    n_cmp++;
    if (n != 1 || rsp_op !== 2'b01 || rsp_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL write_ack got delay=%0d op=%b data=%h required 1/01/0000", n, rsp_op, rsp_data);
    end
`else
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_no_ack got rsp_valid=%b required 0", rsp_valid);
    end
`endif
    wait_idle();
    n_cmp++;
    if (q_rsp.size() != e_rsp.size()) begin
      n_fail++;
      $display("FAIL write_ack_count got %0d required %0d", q_rsp.size(), e_rsp.size());
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    clear_queues();
    fork
      begin
        for (int k = 0; k < 80; k++) begin
          logic [1:0]  op;
          logic [15:0] b;
          logic [15:0] d;
          op = 2'($urandom_range(0, 3));
          b  = ($urandom_range(0, 1) == 1) ? 16'h00FF : 16'($urandom);
          d  = ($urandom_range(0, 1) == 1) ? ref_mem[$urandom_range(0, 15)] : 16'($urandom);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(op, 9'($urandom_range(0, 15)), b, d);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 2) != 0);
        end
        rsp_ready = 1'b1;
      end
    join
    wait_idle();
    n_cmp++;
    if (q_rsp.size() != e_rsp.size() || q_iss.size() != e_iss.size()) begin
      n_fail++;
      $display("FAIL rand_count got rsp=%0d iss=%0d required %0d/%0d",
               q_rsp.size(), q_iss.size(), e_rsp.size(), e_iss.size());
    end
    foreach (e_iss[i]) if (i < q_iss.size()) begin
      n_cmp++;
      if (q_iss[i] !== e_iss[i]) begin
        n_fail++;
        $display("FAIL rand_iss[%0d] got %h required %h", i, q_iss[i], e_iss[i]);
      end
    end
    foreach (e_rsp[i]) if (i < q_rsp.size()) begin
      n_cmp++;
      if (q_rsp[i] !== e_rsp[i]) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d] got %h required %h", i, q_rsp[i], e_rsp[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_search();
    test_back_to_back();
    test_nop();
    test_write_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
